// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding, idle opcode and datapath width.
package alu_pkg;

  localparam int DATA_W = 32;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_SLL  = 4'd5;
  localparam logic [3:0] OP_SRL  = 4'd6;
  localparam logic [3:0] OP_SRA  = 4'd7;
  localparam logic [3:0] OP_SLTU = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_NOP  = 4'hF;

  function automatic logic op_illegal(input logic [3:0] op);
    return op > OP_SLT;
  endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Request, ALU-side and response signals of the issue controller.
interface alu_issue_ctrl_if #(parameter int TAG_W = 4);
  import alu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic [3:0]        req_op;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [TAG_W-1:0]  req_tag;

  logic [DATA_W-1:0] alu_in0;
  logic [DATA_W-1:0] alu_in1;
  logic [3:0]        control_signal;
  logic [DATA_W-1:0] alu_out;
  logic              zero_flag;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;
  logic              rsp_illegal;
  logic [TAG_W-1:0]  rsp_tag;

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, alu_out, zero_flag, rsp_ready,
    output req_ready, alu_in0, alu_in1, control_signal,
           rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_tag
  );

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, alu_out, zero_flag, rsp_ready,
    input  req_ready, alu_in0, alu_in1, control_signal,
           rsp_valid, rsp_result, rsp_zero, rsp_illegal, rsp_tag
  );

endinterface

// File: rtl/alu_ctrl_fifo.sv
// Synchronous FIFO with registered occupancy; push when full and pop when empty are ignored.
module alu_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     clear,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: occupancy alone decides what is readable.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue controller: request FIFO -> issue reg (drives ALU) -> ALU reg -> response FIFO,
// with credits bounding in-flight ops to the free response slots.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int REQ_DEPTH = 4,
  parameter int RSP_DEPTH = 4,
  parameter int TAG_W     = 4
) (
  input  logic                 clk,
  input  logic                 clear,
  alu_issue_ctrl_if.slave      bus,
  output logic                 busy,
  output logic [DATA_W-1:0]    issue_count
);
  localparam int REQ_W = 4 + 2*DATA_W + TAG_W;
  localparam int RSP_W = DATA_W + 2 + TAG_W;
  localparam int CNT_W = $clog2(RSP_DEPTH) + 2;

  logic [REQ_W-1:0]             req_wdata, req_rdata;
  logic                         req_full, req_empty;
  logic [$clog2(REQ_DEPTH):0]   req_count;
  logic [RSP_W-1:0]             rsp_wdata, rsp_rdata;
  logic                         rsp_full, rsp_empty;
  logic [$clog2(RSP_DEPTH):0]   rsp_count;

  logic              i_valid_q, e_valid_q, e_ill_q;
  logic [3:0]        i_op_q;
  logic [DATA_W-1:0] i_a_q, i_b_q;
  logic [TAG_W-1:0]  i_tag_q, e_tag_q;
  logic [DATA_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0]  in_flight;
  logic              issue;
  logic [DATA_W-1:0] w_result;
  logic              w_zero;

  assign req_wdata = {bus.req_op, bus.req_a, bus.req_b, bus.req_tag};

  alu_ctrl_fifo #(.WIDTH(REQ_W), .DEPTH(REQ_DEPTH)) u_req_fifo (
    .clk(clk), .clear(clear),
    .push(bus.req_valid), .pop(issue),
    .wdata(req_wdata), .rdata(req_rdata),
    .full(req_full), .empty(req_empty), .count(req_count)
  );

  // rsp_count is the registered occupancy, so a pop this cycle frees its credit next cycle.
  assign in_flight   = CNT_W'(i_valid_q) + CNT_W'(e_valid_q) + CNT_W'(rsp_count);
  assign issue       = !req_empty && (in_flight < CNT_W'(RSP_DEPTH));
  assign issue_cnt_d = issue ? issue_cnt_q + 1'b1 : issue_cnt_q;

  always_ff @(posedge clk) begin
    if (clear) begin
      i_valid_q   <= 1'b0;
      i_op_q      <= OP_NOP;
      i_a_q       <= '0;
      i_b_q       <= '0;
      i_tag_q     <= '0;
      e_valid_q   <= 1'b0;
      e_ill_q     <= 1'b0;
      e_tag_q     <= '0;
      issue_cnt_q <= '0;
    end else begin
      i_valid_q <= issue;
      if (issue) {i_op_q, i_a_q, i_b_q, i_tag_q} <= req_rdata;
      e_valid_q   <= i_valid_q;
      e_ill_q     <= op_illegal(i_op_q);
      e_tag_q     <= i_tag_q;
      issue_cnt_q <= issue_cnt_d;
    end
  end

  assign bus.alu_in0        = i_a_q;
  assign bus.alu_in1        = i_b_q;
  assign bus.control_signal = i_valid_q ? i_op_q : OP_NOP;

  assign w_result  = e_ill_q ? '0 : bus.alu_out;
  assign w_zero    = e_ill_q | bus.zero_flag;
  assign rsp_wdata = {w_result, w_zero, e_ill_q, e_tag_q};

  alu_ctrl_fifo #(.WIDTH(RSP_W), .DEPTH(RSP_DEPTH)) u_rsp_fifo (
    .clk(clk), .clear(clear),
    .push(e_valid_q && !rsp_full), .pop(bus.rsp_ready),
    .wdata(rsp_wdata), .rdata(rsp_rdata),
    .full(rsp_full), .empty(rsp_empty), .count(rsp_count)
  );

  assign {bus.rsp_result, bus.rsp_zero, bus.rsp_illegal, bus.rsp_tag} = rsp_rdata;
  assign bus.rsp_valid = !rsp_empty;
  assign bus.req_ready = !req_full;

  assign busy        = (req_count != '0) || i_valid_q || e_valid_q || !rsp_empty;
  assign issue_count = issue_cnt_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl with a behavioural registered ALU attached.
module tb_alu_issue_ctrl;
  logic        clk = 1'b0;
  logic        clear = 1'b1;
  logic        busy;
  logic [31:0] issue_count;

  alu_issue_ctrl_if #(.TAG_W(4)) bus();

  alu_issue_ctrl #(.REQ_DEPTH(4), .RSP_DEPTH(4), .TAG_W(4)) dut (
    .clk(clk), .clear(clear), .bus(bus), .busy(busy), .issue_count(issue_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic        ill;
    logic [3:0]  tag;
  } exp_t;

  exp_t        exp_q[$];
  int          pop_cyc[$];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          n_issued = 0;
  logic        hold_pending = 1'b0;
  logic [37:0] hold_val;

  function automatic logic [31:0] ref_op(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    int unsigned sh;
    sh = int'(b % 32);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a << sh;
      4'd6: return a >> sh;
      4'd7: return 32'($signed(a) >>> sh);
      4'd8: return (a < b) ? 32'd1 : 32'd0;
      4'd9: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  // Registered ALU sitting on the controller's ALU port.
  always @(posedge clk) begin
    if (clear) bus.alu_out <= 32'd0;
    else       bus.alu_out <= ref_op(bus.control_signal, bus.alu_in0, bus.alu_in1);
  end
  assign bus.zero_flag = (bus.alu_out == 32'd0);

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor: the handshake seen here completes at the following posedge.
  always @(negedge clk) begin
    exp_t e;
    if (clear) begin
      hold_pending = 1'b0;
    end else begin
      if (hold_pending && bus.rsp_valid)
        chk("rsp_stable", {26'd0, bus.rsp_result, bus.rsp_zero, bus.rsp_illegal, bus.rsp_tag},
            {26'd0, hold_val});
      hold_pending = 1'b0;
      if (bus.rsp_valid && !bus.rsp_ready) begin
        hold_pending = 1'b1;
        hold_val = {bus.rsp_result, bus.rsp_zero, bus.rsp_illegal, bus.rsp_tag};
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got tag %0h result %0h, expected no response",
                   bus.rsp_tag, bus.rsp_result);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_result",  64'(bus.rsp_result),  64'(e.res));
          chk("rsp_zero",    64'(bus.rsp_zero),    64'(e.zero));
          chk("rsp_illegal", 64'(bus.rsp_illegal), 64'(e.ill));
          chk("rsp_tag",     64'(bus.rsp_tag),     64'(e.tag));
          pop_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [3:0] tag);
    exp_t e;
    int   n;
    logic ok;
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_tag   = tag;
    n  = 0;
    ok = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk);
      if (bus.req_ready) ok = 1'b1;
      else n++;
    end
    if (ok) begin
      e.ill  = (op > 4'd9);
      e.res  = e.ill ? 32'd0 : ref_op(op, a, b);
      e.zero = (e.res == 32'd0);
      e.tag  = tag;
      exp_q.push_back(e);
      n_issued++;
    end else begin
      checks++;
      failures++;
      $display("FAIL req_accept_timeout: got req_ready=0 for %0d cycles, expected acceptance", n);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    bus.rsp_ready = 1'b1;
    n = 0;
    while (n < 300 && !(exp_q.size() == 0 && !busy)) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_pending", 64'(exp_q.size()), 64'd0);
    chk("drain_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] op;
    logic       rnd_done;
    bus.req_valid = 1'b0;
    bus.req_op    = 4'd0;
    bus.req_a     = 32'd0;
    bus.req_b     = 32'd0;
    bus.req_tag   = 4'd0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;

    chk("reset_req_ready", 64'(bus.req_ready), 64'd1);
    chk("reset_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_alu_in0", 64'(bus.alu_in0), 64'd0);
    chk("reset_alu_in1", 64'(bus.alu_in1), 64'd0);
    chk("reset_ctrl", 64'(bus.control_signal), 64'hF);
    chk("reset_issue_count", 64'(issue_count), 64'd0);

    // Single op and its latency
    send(4'd0, 32'd5, 32'd7, 4'd3);
    repeat (2) @(posedge clk);
    #1;
    chk("lat_before_t3", 64'(bus.rsp_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_at_t3", 64'(bus.rsp_valid), 64'd1);
    chk("single_issue_count", 64'(issue_count), 64'd1);
    drain();

    // Back-to-back, one response per cycle
    pop_cyc.delete();
    send(4'd1, 32'd9, 32'd9, 4'd1);
    send(4'd9, 32'hFFFF_FFFF, 32'd1, 4'd2);
    send(4'd7, 32'h8000_0000, 32'd4, 4'd3);
    send(4'd3, 32'h0000_00F0, 32'h0000_000F, 4'd4);
    drain();
    chk("b2b_count", 64'(pop_cyc.size()), 64'd4);
    for (int i = 1; i < pop_cyc.size(); i++)
      chk("b2b_spacing", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);

    // Backpressure: 4 responses held plus 4 queued requests fill the block
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(4'd0, 32'(i), 32'd100, 4'(i));
    repeat (6) @(posedge clk);
    #1;
    chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
    chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
    chk("bp_busy", 64'(busy), 64'd1);
    fork
      begin
        send(4'd0, 32'd8, 32'd100, 4'd8);
        send(4'd0, 32'd9, 32'd100, 4'd9);
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
      end
    join
    drain();

    // Illegal opcode
    send(4'hC, 32'd1, 32'd1, 4'd6);
    drain();

    // Randomized traffic with random response backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
          if ($urandom_range(0, 4) == 0) send(op, 32'd77, 32'd77, 4'(i));
          else send(op, $urandom, $urandom, 4'(i));
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          bus.rsp_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    drain();
    chk("issue_count_total", 64'(issue_count), 64'(n_issued));

    // Clear mid-stream drops everything
    bus.rsp_ready = 1'b0;
    send(4'd0, 32'd1, 32'd2, 4'd1);
    send(4'd0, 32'd3, 32'd4, 4'd2);
    send(4'd0, 32'd5, 32'd6, 4'd3);
    clear = 1'b1;
    exp_q.delete();
    n_issued = 0;
    @(posedge clk);
    #1;
    clear = 1'b0;
    chk("clr_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("clr_busy", 64'(busy), 64'd0);
    chk("clr_issue_count", 64'(issue_count), 64'd0);
    chk("clr_ctrl", 64'(bus.control_signal), 64'hF);
    chk("clr_req_ready", 64'(bus.req_ready), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("clr_no_late_rsp", 64'(bus.rsp_valid), 64'd0);
    bus.rsp_ready = 1'b1;
    send(4'd0, 32'd1, 32'd1, 4'd5);
    drain();
    chk("clr_issue_count_after", 64'(issue_count), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
